// File: rtl/robot_pkg.sv
// robot_pkg: state encodings, motor-output decode and counter sizing shared by
// the wall-follower controller and its sensor debouncers.
package robot_pkg;

   typedef enum logic [1:0] {
      SEEK       = 2'b00,
      FOLLOW     = 2'b01,
      ROT_AWAY   = 2'b10,
      ROT_TOWARD = 2'b11
   } state_t;

   typedef struct packed {
      logic a;
      logic r;
      logic rdir;
   } motor_t;

   localparam motor_t MOTOR_OFF = 3'b000;
   localparam motor_t MOTOR_FWD = 3'b100;
   localparam motor_t MOTOR_ROT = 3'b010;

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Rotation away from the wall is clockwise when the wall is on the left.
   function automatic motor_t motor_decode(input state_t s, input logic follow_right);
      motor_t m;
      case (s)
         ROT_AWAY: begin
            m      = MOTOR_ROT;
            m.rdir = ~follow_right;
         end
         ROT_TOWARD: begin
            m      = MOTOR_ROT;
            m.rdir = follow_right;
         end
         default: m = MOTOR_FWD;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser followed by a run-length debouncer; the
// filtered output flips after DEB_CYCLES consecutive differing samples.
module sensor_debounce
   import robot_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_filt
);

   localparam int CW = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_filt;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_filt  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_filt) begin
            if (r_cnt == CNT_LAST) begin
               r_filt <= r_sync2;
               r_cnt  <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_filt = r_filt;

endmodule

// File: rtl/robot_wall_follower.sv
// robot_wall_follower: debounced four-state wall-following controller with timed
// rotation steps. Optional stuck detection enabled by ROBOT_STUCK_DETECT_EN.
module robot_wall_follower
   import robot_pkg::*;
#(
   parameter int DEB_CYCLES   = 4,
   parameter int ROT_CYCLES   = 8,
   parameter int MAX_ROT      = 4,
   parameter int FOLLOW_RIGHT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       h,
   input  logic       l,
   output logic       a,
   output logic       r,
   output logic       rdir,
   output logic [1:0] state,
   output logic       stuck
);

   localparam int RW = cnt_width(ROT_CYCLES);
   localparam logic [RW-1:0] ROT_LAST = RW'(ROT_CYCLES - 1);
   localparam logic FR = (FOLLOW_RIGHT != 0);

   if (DEB_CYCLES < 1 || ROT_CYCLES < 1 || MAX_ROT < 1) begin : g_param_check
      $error("robot_wall_follower: DEB_CYCLES, ROT_CYCLES and MAX_ROT must be >= 1");
   end

   logic          w_hf;
   logic          w_lf;
   state_t        r_state;
   state_t        w_state_next;
   logic [RW-1:0] r_rot_cnt;
   logic [RW-1:0] w_rot_cnt_next;
   logic          w_rot_done;
   logic          w_stuck;
   logic          w_stuck_next;
   motor_t        r_motor;
   motor_t        w_motor_next;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h (
      .clk    (clk),
      .rst_n  (reset),
      .i_raw  (h),
      .o_filt (w_hf)
   );

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
      .clk    (clk),
      .rst_n  (reset),
      .i_raw  (l),
      .o_filt (w_lf)
   );

   assign w_rot_done = (r_state == ROT_AWAY || r_state == ROT_TOWARD) && (r_rot_cnt == ROT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= SEEK;
         r_rot_cnt <= '0;
         r_motor   <= MOTOR_OFF;
      end else begin
         r_state   <= w_state_next;
         r_rot_cnt <= w_rot_cnt_next;
         r_motor   <= w_motor_next;
      end
   end

   // Sensors are only consulted outside a rotation step or at its terminal count.
   always_comb begin
      w_state_next   = r_state;
      w_rot_cnt_next = r_rot_cnt;
      if (enable && !w_stuck) begin
         case (r_state)
            SEEK: begin
               if (w_hf) begin
                  w_state_next   = ROT_AWAY;
                  w_rot_cnt_next = '0;
               end else if (w_lf) begin
                  w_state_next = FOLLOW;
               end
            end
            FOLLOW: begin
               if (w_hf) begin
                  w_state_next   = ROT_AWAY;
                  w_rot_cnt_next = '0;
               end else if (!w_lf) begin
                  w_state_next   = ROT_TOWARD;
                  w_rot_cnt_next = '0;
               end
            end
            default: begin
               if (w_rot_done) begin
                  w_rot_cnt_next = '0;
                  if (w_hf)      w_state_next = ROT_AWAY;
                  else if (w_lf) w_state_next = FOLLOW;
                  else           w_state_next = SEEK;
               end else begin
                  w_rot_cnt_next = r_rot_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_motor_next = MOTOR_OFF;
      if (enable && !w_stuck_next) begin
         w_motor_next = motor_decode(w_state_next, FR);
      end
   end

`ifdef ROBOT_STUCK_DETECT_EN
   localparam int SW = cnt_width(MAX_ROT + 1);
   localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_ROT);

   logic [SW-1:0] r_step;
   logic [SW-1:0] w_step_next;
   logic [SW-1:0] w_step_inc;
   logic          r_stuck;

   assign w_step_inc = r_step + 1'b1;

   // A terminal count that lands in SEEK/FOLLOW clears the run instead of counting.
   always_comb begin
      w_step_next  = r_step;
      w_stuck_next = r_stuck;
      if (enable && !r_stuck) begin
         if (w_state_next == SEEK || w_state_next == FOLLOW) begin
            w_step_next = '0;
         end else if (w_rot_done) begin
            w_step_next = w_step_inc;
            if (w_step_inc == STEP_LIMIT) w_stuck_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_step  <= '0;
         r_stuck <= 1'b0;
      end else begin
         r_step  <= w_step_next;
         r_stuck <= w_stuck_next;
      end
   end

   assign w_stuck = r_stuck;
`else
   assign w_stuck      = 1'b0;
   assign w_stuck_next = 1'b0;
`endif

   assign a     = r_motor.a;
   assign r     = r_motor.r;
   assign rdir  = r_motor.rdir;
   assign state = r_state;
   assign stuck = w_stuck;

endmodule

// File: tb/tb_robot_wall_follower.sv
// tb_robot_wall_follower: vector table, hand sequences and randomized run against
// a behavioural model; covers both FOLLOW_RIGHT settings side by side.
module tb_robot_wall_follower;

   localparam int DEB_CYCLES = 4;
   localparam int ROT_CYCLES = 8;
   localparam int MAX_ROT    = 4;
`ifdef ROBOT_STUCK_DETECT_EN
   localparam bit STUCK_EN = 1'b1;
`else
   localparam bit STUCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       h;
   logic       l;
   logic       a0, r0, rdir0, stuck0;
   logic [1:0] state0;
   logic       a1, r1, rdir1, stuck1;
   logic [1:0] state1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   robot_wall_follower #(.DEB_CYCLES(DEB_CYCLES), .ROT_CYCLES(ROT_CYCLES),
                         .MAX_ROT(MAX_ROT), .FOLLOW_RIGHT(0)) u_dut0 (
      .clk(clk), .reset(reset), .enable(enable), .h(h), .l(l),
      .a(a0), .r(r0), .rdir(rdir0), .state(state0), .stuck(stuck0)
   );

   robot_wall_follower #(.DEB_CYCLES(DEB_CYCLES), .ROT_CYCLES(ROT_CYCLES),
                         .MAX_ROT(MAX_ROT), .FOLLOW_RIGHT(1)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .h(h), .l(l),
      .a(a1), .r(r1), .rdir(rdir1), .state(state1), .stuck(stuck1)
   );

   // ---------------- behavioural reference ----------------
   typedef struct {
      bit s1;
      bit s2;
      bit f;
      int run;
   } sens_t;

   sens_t m_h, m_l;
   int    m_state;      // 0 seek, 1 follow, 2 rotate away, 3 rotate toward
   int    m_left;       // edges still to go before the current step's terminal count
   int    m_steps;
   bit    m_stuck;
   bit    m_on;         // outputs enabled after the last edge

   function automatic sens_t deb_step(input sens_t x, input bit raw);
      sens_t y;
      y = x;
      if (x.s2 != x.f) begin
         y.run = x.run + 1;
         if (y.run == DEB_CYCLES) begin
            y.f   = x.s2;
            y.run = 0;
         end
      end else begin
         y.run = 0;
      end
      y.s1 = raw;
      y.s2 = x.s1;
      return y;
   endfunction

   task automatic model_reset();
      m_h     = '{0, 0, 0, 0};
      m_l     = '{0, 0, 0, 0};
      m_state = 0;
      m_left  = 0;
      m_steps = 0;
      m_stuck = 0;
      m_on    = 0;
   endtask

   task automatic start_rot(input int s);
      m_state = s;
      m_left  = ROT_CYCLES - 1;
   endtask

   task automatic model_step();
      bit hf, lf;
      hf = m_h.f;
      lf = m_l.f;
      if (enable && !m_stuck) begin
         if (m_state == 0) begin
            if (hf) start_rot(2);
            else if (lf) m_state = 1;
         end else if (m_state == 1) begin
            if (hf) start_rot(2);
            else if (!lf) start_rot(3);
         end else if (m_left > 0) begin
            m_left--;
         end else begin
            m_steps++;
            if (hf) start_rot(2);
            else if (lf) m_state = 1;
            else m_state = 0;
            if (m_state < 2) m_steps = 0;
            else if (STUCK_EN && m_steps >= MAX_ROT) m_stuck = 1;
         end
      end
      m_on = enable && !m_stuck;
      m_h  = deb_step(m_h, h);
      m_l  = deb_step(m_l, l);
   endtask

   // {stuck, state, a, r, rdir}
   function automatic logic [5:0] model_vec(input bit right);
      bit ea, er, ed;
      ea = m_on && (m_state < 2);
      er = m_on && (m_state >= 2);
      ed = er && ((m_state == 2) ? !right : right);
      return {m_stuck, 2'(m_state), ea, er, ed};
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_reset();
      else model_step();
      @(negedge clk);
      check("model_dut0", {2'b0, stuck0, state0, a0, r0, rdir0}, {2'b0, model_vec(1'b0)});
      check("model_dut1", {2'b0, stuck1, state1, a1, r1, rdir1}, {2'b0, model_vec(1'b1)});
   endtask

   task automatic async_reset_check(input string name);
      reset = 1'b0;
      #1;
      model_reset();
      check(name, {2'b0, stuck0, state0, a0, r0, rdir0}, 8'h00);
      $display("reset asserted asynchronously: %s", name);
   endtask

   task automatic wait_state(input logic [1:0] target, input int limit, input string name);
      int n;
      n = 0;
      while (state0 !== target && n < limit) begin
         tick();
         n++;
      end
      check(name, {6'b0, state0}, {6'b0, target});
   endtask

   typedef struct {
      bit         h;
      bit         l;
      bit         en;
      int         n;
      logic [1:0] st;
      bit         a;
      bit         r;
      bit         rdir;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rcount;
      int lim;

      vecs[0]  = '{1, 0, 1, 3,              2'b00, 1, 0, 0};
      vecs[1]  = '{0, 0, 1, DEB_CYCLES + 2, 2'b00, 1, 0, 0};
      vecs[2]  = '{0, 1, 1, DEB_CYCLES + 2, 2'b00, 1, 0, 0};
      vecs[3]  = '{0, 1, 1, 1,              2'b01, 1, 0, 0};
      vecs[4]  = '{1, 1, 1, DEB_CYCLES + 2, 2'b01, 1, 0, 0};
      vecs[5]  = '{1, 1, 1, 1,              2'b10, 0, 1, 1};
      vecs[6]  = '{0, 1, 1, ROT_CYCLES - 1, 2'b10, 0, 1, 1};
      vecs[7]  = '{0, 1, 1, 1,              2'b01, 1, 0, 0};
      vecs[8]  = '{0, 0, 1, DEB_CYCLES + 2, 2'b01, 1, 0, 0};
      vecs[9]  = '{0, 0, 1, 1,              2'b11, 0, 1, 0};
      vecs[10] = '{0, 0, 1, ROT_CYCLES - 1, 2'b11, 0, 1, 0};
      vecs[11] = '{0, 0, 1, 1,              2'b00, 1, 0, 0};

      reset  = 1'b0;
      enable = 1'b0;
      h      = 1'b0;
      l      = 1'b0;
      model_reset();
      repeat (3) tick();
      check("reset_state", {2'b0, stuck0, state0, a0, r0, rdir0}, 8'h00);
      $display("reset held: state=%b a=%b r=%b", state0, a0, r0);

      reset  = 1'b1;
      enable = 1'b1;
      tick();
      check("first_edge_a", {6'b0, state0, a0}, 8'h01);
      $display("first edge after release: a=%b state=%b", a0, state0);

      for (int i = 0; i < 12; i++) begin
         h      = vecs[i].h;
         l      = vecs[i].l;
         enable = vecs[i].en;
         for (int k = 0; k < vecs[i].n; k++) tick();
         check($sformatf("vec%0d", i), {4'b0, state0, a0, r0, rdir0},
               {4'b0, vecs[i].st, vecs[i].a, vecs[i].r, vecs[i].rdir});
         check($sformatf("vec%0d_right", i), {7'b0, rdir1},
               {7'b0, vecs[i].r & ~vecs[i].rdir});
         $display("vec %0d: h=%b l=%b en=%b n=%0d -> state=%b a=%b r=%b rdir=%b/%b",
                  i, h, l, enable, vecs[i].n, state0, a0, r0, rdir0, rdir1);
      end

      // enable pause inside a rotation step
      h = 1'b1;
      wait_state(2'b10, 20, "pause_enter_rot");
      h = 1'b0;
      rcount = (r0 === 1'b1) ? 1 : 0;
      repeat (3) begin
         tick();
         if (r0 === 1'b1) rcount++;
      end
      enable = 1'b0;
      repeat (5) tick();
      check("pause_held", {4'b0, state0, a0, r0, rdir0}, {4'b0, 2'b10, 3'b000});
      enable = 1'b1;
      lim = 0;
      while (state0 === 2'b10 && lim < 20) begin
         tick();
         if (r0 === 1'b1) rcount++;
         lim++;
      end
      check("pause_r_edges", 8'(rcount), 8'(ROT_CYCLES));
      check("pause_exit_seek", {6'b0, state0}, 8'h00);
      $display("enable pause: rotation edges=%0d state=%b", rcount, state0);

      // reset in the middle of ROT_AWAY
      h = 1'b1;
      wait_state(2'b10, 20, "midrot_enter");
      repeat (2) tick();
      async_reset_check("midrot_reset");
      h = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("midrot_release_a", {6'b0, state0, a0}, 8'h01);
      $display("reset mid-rotation released: a=%b state=%b", a0, state0);

      // randomized run
      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) h = ~h;
            if ($urandom_range(0, 5) == 0) l = ~l;
            enable = ($urandom_range(0, 9) != 0);
            tick();
         end
         $display("random block %0d done: state=%b stuck=%b", blk, state0, stuck0);
         async_reset_check($sformatf("random_reset%0d", blk));
         tick();
         reset = 1'b1;
      end

      // long-term blocked front sensor
      h      = 1'b1;
      l      = 1'b0;
      enable = 1'b1;
      rcount = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (r0 === 1'b1) rcount++;
      end
      if (STUCK_EN) begin
         check("stuck_flag", {5'b0, stuck0, a0, r0}, 8'h04);
         check("stuck_rot_edges", 8'(rcount), 8'(MAX_ROT * ROT_CYCLES));
      end else begin
         check("no_stuck", {5'b0, stuck0, a0, r0}, 8'h01);
         check("no_stuck_state", {6'b0, state0}, 8'h02);
      end
      $display("blocked front: stuck=%b r=%b rotation edges=%0d", stuck0, r0, rcount);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/robot_wall_follower.md
# robot_wall_follower

Parametrised successor of the two-state wall-following robot controller. Drives the motor stage from a front sensor `h` and a side sensor `l`. Adds input debouncing, timed rotation steps, explicit rotation direction, left/right wall selection and an enable. It sits between the raw sensor pins and the motor driver in the robot top level.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive synchronised samples a sensor must differ before its filtered value flips (≥1).
- `ROT_CYCLES`, 8: clock cycles one rotation step lasts (≥1).
- `MAX_ROT`, 4: consecutive rotation steps before stuck is declared (used only with the macro).
- `FOLLOW_RIGHT`, 0: 0 = wall kept on the left, 1 = wall kept on the right; inverts `rdir` only.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: high = run; low = freeze FSM and counters, motors off.
- `h` in 1: raw front (head) sensor, asynchronous.
- `l` in 1: raw side sensor, asynchronous.
- `a` out 1: advance forward.
- `r` out 1: rotate in place.
- `rdir` out 1: rotation direction, 1 = clockwise, 0 = counter-clockwise; 0 when not rotating.
- `state` out 2: current state code.
- `stuck` out 1: sticky stuck flag.

## Operation
- Each sensor path: 2-flop synchroniser, then debounce counter. The counter increments while the synchronised value ≠ filtered value and clears when they are equal. The filtered value flips and the counter clears on the DEB_CYCLES-th differing edge.
- FSM on filtered `hf`, `lf`. States: SEEK=00, FOLLOW=01, ROT_AWAY=10, ROT_TOWARD=11.
- SEEK: `hf` → ROT_AWAY; else `lf` → FOLLOW; else stay.
- FOLLOW: `hf` → ROT_AWAY; else `!lf` → ROT_TOWARD; else stay.
- ROT_AWAY / ROT_TOWARD: the rotation counter runs 0..ROT_CYCLES-1. At terminal count:
  - `hf` → ROT_AWAY, with the counter restarted.
  - else `lf` → FOLLOW.
  - else SEEK.
- Sensor changes during a rotation step are ignored until its terminal count.
- Outputs (Moore, registered):
  - SEEK/FOLLOW: a=1, r=0, rdir=0.
  - ROT_AWAY: a=0, r=1, rdir=~FOLLOW_RIGHT.
  - ROT_TOWARD: a=0, r=1, rdir=FOLLOW_RIGHT.
- `enable` low: state and rotation counter hold; a=r=rdir=0 from the next edge; debouncers keep running. When `enable` rises, the FSM resumes mid-step with the counter value intact.
- Counter widths: $clog2 of the parameter, minimum 1 bit.

## Timing
- Reset values: a=0, r=0, rdir=0, state=00, stuck=0; all counters, synchronisers and filtered sensors 0.
- Reset mid-operation clears everything immediately, regardless of state or enable.
- First edge after reset release with enable=1: a=1 (SEEK).
- Raw sensor change stable before edge 1: filtered value flips at edge DEB_CYCLES+2; state and outputs update at edge DEB_CYCLES+3 (edge 7 at defaults).
- Glitches shorter than DEB_CYCLES synchronised samples never reach the FSM.
- A rotation step holds r=1 for exactly ROT_CYCLES edges when enable stays high.

## Configuration
- `ROBOT_STUCK_DETECT_EN` defined:
  - A rotation-step counter increments at each rotation terminal count and clears on entering SEEK or FOLLOW.
  - When it reaches MAX_ROT, `stuck` goes to 1 and a=r=rdir=0.
  - The FSM then freezes until reset.
- `ROBOT_STUCK_DETECT_EN` undefined: no step counter; `stuck` tied 0; rotation may continue indefinitely.

## Structure
- Package `robot_pkg`: state enum (SEEK, FOLLOW, ROT_AWAY, ROT_TOWARD) with the fixed 2-bit encodings, and the output decode constants.
- Sub-module `sensor_debounce` (parameter DEB_CYCLES; synchroniser + counter), instantiated twice, for `h` and `l`.

## Test plan
- Reset low during ROT_AWAY → a=r=0, state=00 immediately; release with enable=1 → a=1 at first edge.
- Defaults, `h` pulsed high 3 cycles → state stays 00, a=1 throughout.
- SEEK, `l`=1 held → state=01 at edge 7. Then `h`=1 → ROT_AWAY, r=1, rdir=1 for 8 cycles. Then `h`=0, `l`=1 → state=01.
- FOLLOW, `l` dropped → ROT_TOWARD, rdir=0 for 8 cycles, then SEEK with a=1. Repeat with FOLLOW_RIGHT=1 → rdir values inverted.
- `enable` low for 5 cycles at rotation count 3 → a=r=0 and state held. Re-enabled → r=1 for the remaining 5 cycles.
- Macro defined, `h` held 1 → stuck=1, a=r=0 after 4 steps (32 cycles of rotation). Macro undefined → rotation continues, stuck=0.
